// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
// Holds the controller state encoding, the word-alignment mask, the default
// access timeout and a small address-alignment helper.
package mem_access_ctrl_pkg;

  // Controller state encoding (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  // Clears the byte-offset bits of a byte address to form a word address
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Default number of cycles an access may wait for mem_ready
  localparam int DEFAULT_TIMEOUT = 16;

  // True when a byte address does not fall on a word boundary
  function automatic logic isMisaligned(input logic [31:0] addr);
    return ((addr & ~WORD_ALIGN_MASK) != 32'h0000_0000);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/ready bus between the MEM-stage access controller and
// the data memory.
//   master (controller): drives mem_req, mem_we, mem_addr, mem_wdata;
//                        receives mem_ready, mem_rdata.
//   slave  (memory)    : the mirror image.
interface mem_access_ctrl_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/mem_access_ctrl_sat_counter.sv
// Generic saturating up-counter for performance monitoring.
// Ports:
//   clk   - clock
//   clr   - synchronous clear (highest priority)
//   en    - count this cycle
//   count - current value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  // Count enabled cycles, sticking at the maximum value
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= ZERO;
    end else if (en && (count != MAX)) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller.
// Issues the EX/MEM load/store to a variable-latency memory, freezes the
// front of the pipeline while the access is outstanding, and flags misaligned
// word accesses and memory timeouts (killing the faulting register write).
// Ports:
//   clk, rst            - pipeline clock, synchronous active-high reset
//   MemRead, MemWrite   - access type from EX/MEM (both set = write)
//   RegWrite_in         - register write enable from EX/MEM
//   AluResult           - byte address from EX/MEM
//   WriteData           - store data from EX/MEM
//   mem                 - request/ready bus to the data memory (master side)
//   rd_data             - load data to MEM/WB
//   RegWrite_out        - register write enable to MEM/WB, cleared on fault
//   stall               - freezes PC, IF/ID, ID/EX, EX/MEM
//   misalign, bus_err   - one-cycle fault pulses
//   stall_cycles        - saturating count of stalled cycles
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               RegWrite_in,
  input  logic [31:0]        AluResult,
  input  logic [31:0]        WriteData,
  mem_access_ctrl_if.master  mem,
  output logic [31:0]        rd_data,
  output logic               RegWrite_out,
  output logic               stall,
  output logic               misalign,
  output logic               bus_err,
  output logic [CNT_W-1:0]   stall_cycles
);

  // Wait counter only needs to reach TIMEOUT-1
  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WC_ZERO = {WCW{1'b0}};
  localparam logic [WCW-1:0] WC_ONE  = WCW'(1'b1);
  localparam logic [WCW-1:0] WC_LAST = WCW'(TIMEOUT - 1);

  logic [1:0]     stateR;
  logic [1:0]     stateNxt;
  logic [WCW-1:0] waitCntR;
  logic [WCW-1:0] waitCntNxt;
  logic [31:0]    rdDataR;
  logic           access;
  logic           mis;
  logic           memReq;
  logic           loadDone;

  // Next-state and control decode; reset forces the idle/no-access outputs
  always_comb begin
    access       = MemRead | MemWrite;
    mis          = access & isMisaligned(AluResult);
    memReq       = 1'b0;
    stall        = 1'b0;
    misalign     = 1'b0;
    bus_err      = 1'b0;
    RegWrite_out = RegWrite_in;
    stateNxt     = stateR;
    waitCntNxt   = waitCntR;
    if (rst) begin
      stateNxt   = ST_IDLE;
      waitCntNxt = WC_ZERO;
    end else begin
      case (stateR)
        ST_IDLE: begin
          if (mis) begin
            // Never reaches memory; instruction passes through with no write
            misalign     = 1'b1;
            RegWrite_out = 1'b0;
          end else if (access) begin
            memReq = 1'b1;
            if (mem.mem_ready) begin
              stateNxt = ST_IDLE;
            end else begin
              stall      = 1'b1;
              stateNxt   = ST_WAIT;
              waitCntNxt = WC_ONE;
            end
          end else begin
            stateNxt = ST_IDLE;
          end
        end
        ST_WAIT: begin
          // EX/MEM is frozen, so address/data stay stable while requesting
          memReq = 1'b1;
          if (mem.mem_ready) begin
            // Ready wins even on the timeout cycle
            stateNxt   = ST_IDLE;
            waitCntNxt = WC_ZERO;
          end else begin
            stall = 1'b1;
            if (waitCntR == WC_LAST) begin
              stateNxt   = ST_ERR;
              waitCntNxt = WC_ZERO;
            end else begin
              waitCntNxt = waitCntR + WC_ONE;
            end
          end
        end
        ST_ERR: begin
          // Release the pipeline so the faulting instruction leaves MEM
          bus_err      = 1'b1;
          RegWrite_out = 1'b0;
          stateNxt     = ST_IDLE;
        end
        default: begin
          stateNxt   = ST_IDLE;
          waitCntNxt = WC_ZERO;
        end
      endcase
    end
  end

  // Only loads update the held read data; both flags set counts as a store
  assign loadDone = memReq & mem.mem_ready & MemRead & ~MemWrite;

  // State, wait counter and held load data
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR   <= ST_IDLE;
      waitCntR <= WC_ZERO;
      rdDataR  <= 32'h0000_0000;
    end else begin
      stateR   <= stateNxt;
      waitCntR <= waitCntNxt;
      if (loadDone) begin
        rdDataR <= mem.mem_rdata;
      end else begin
        rdDataR <= rdDataR;
      end
    end
  end

  // Forward read data in the completion cycle, otherwise hold the last load
  always_comb begin
    if (memReq & mem.mem_ready) begin
      rd_data = mem.mem_rdata;
    end else begin
      rd_data = rdDataR;
    end
  end

  assign mem.mem_req   = memReq;
  assign mem.mem_we    = MemWrite;
  assign mem.mem_addr  = AluResult & WORD_ALIGN_MASK;
  assign mem.mem_wdata = WriteData;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (stall),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite_in;
  logic [31:0] AluResult;
  logic [31:0] WriteData;
  logic        memReady;
  logic [31:0] memRdata;

  logic [31:0] rd_data;
  logic        RegWrite_out;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic [31:0] stall_cycles;

  // Second instance with a 2-bit counter to exercise saturation
  logic [31:0] rd_data2;
  logic        RegWrite_out2;
  logic        stall2;
  logic        misalign2;
  logic        bus_err2;
  logic [1:0]  stall_cycles2;

  int checks = 0;
  int passes = 0;

  mem_access_ctrl_if memIf ();
  mem_access_ctrl_if memIf2 ();

  assign memIf.mem_ready  = memReady;
  assign memIf.mem_rdata  = memRdata;
  assign memIf2.mem_ready = memReady;
  assign memIf2.mem_rdata = memRdata;

  mem_access_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .RegWrite_in  (RegWrite_in),
    .AluResult    (AluResult),
    .WriteData    (WriteData),
    .mem          (memIf),
    .rd_data      (rd_data),
    .RegWrite_out (RegWrite_out),
    .stall        (stall),
    .misalign     (misalign),
    .bus_err      (bus_err),
    .stall_cycles (stall_cycles)
  );

  mem_access_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .RegWrite_in  (RegWrite_in),
    .AluResult    (AluResult),
    .WriteData    (WriteData),
    .mem          (memIf2),
    .rd_data      (rd_data2),
    .RegWrite_out (RegWrite_out2),
    .stall        (stall2),
    .misalign     (misalign2),
    .bus_err      (bus_err2),
    .stall_cycles (stall_cycles2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idleInputs();
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite_in = 1'b0;
    AluResult   = 32'h0000_0000;
    WriteData   = 32'h0000_0000;
    memReady    = 1'b0;
    memRdata    = 32'h0000_0000;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    idleInputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    // Access presented during reset must not reach memory
    rst = 1'b1;
    MemRead = 1'b1; MemWrite = 1'b0; RegWrite_in = 1'b1;
    AluResult = 32'h0000_0100; memReady = 1'b1; memRdata = 32'hAAAA_5555;
    @(negedge clk);
    checks++; if (memIf.mem_req !== 1'b0) $display("FAIL rst_req: got %0b want 0", memIf.mem_req); else passes++;
    checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %0b want 0", stall); else passes++;
    checks++; if (misalign !== 1'b0 || bus_err !== 1'b0) $display("FAIL rst_faults: got %0b%0b want 00", misalign, bus_err); else passes++;
    nextCycle();
    rst = 1'b0;
    idleInputs();
    @(negedge clk);
    checks++; if (stall_cycles !== 32'd0) $display("FAIL rst_cnt: got %0d want 0", stall_cycles); else passes++;
    checks++; if (rd_data !== 32'h0000_0000) $display("FAIL rst_rdata: got %h want 00000000", rd_data); else passes++;
    checks++; if (memIf.mem_req !== 1'b0) $display("FAIL rst_idle_req: got %0b want 0", memIf.mem_req); else passes++;
    nextCycle();
  endtask

  task automatic test_zero_wait_load();
    applyReset();
    MemRead = 1'b1; RegWrite_in = 1'b1; AluResult = 32'h0000_0100;
    memReady = 1'b1; memRdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (memIf.mem_req !== 1'b1) $display("FAIL zw_req: got %0b want 1", memIf.mem_req); else passes++;
    checks++; if (stall !== 1'b0) $display("FAIL zw_stall: got %0b want 0", stall); else passes++;
    checks++; if (rd_data !== 32'hDEAD_BEEF) $display("FAIL zw_rdata: got %h want deadbeef", rd_data); else passes++;
    checks++; if (memIf.mem_addr !== 32'h0000_0100 || memIf.mem_we !== 1'b0) $display("FAIL zw_bus: got addr %h we %0b want 00000100 0", memIf.mem_addr, memIf.mem_we); else passes++;
    checks++; if (RegWrite_out !== 1'b1) $display("FAIL zw_regwrite: got %0b want 1", RegWrite_out); else passes++;
    nextCycle();
    idleInputs();
    @(negedge clk);
    checks++; if (rd_data !== 32'hDEAD_BEEF) $display("FAIL zw_rdata_held: got %h want deadbeef", rd_data); else passes++;
    checks++; if (stall_cycles !== 32'd0) $display("FAIL zw_cnt: got %0d want 0", stall_cycles); else passes++;
    nextCycle();
  endtask

  task automatic test_store_3wait();
    logic expStall;
    applyReset();
    MemWrite = 1'b1; AluResult = 32'h0000_0204; WriteData = 32'hCAFE_0001;
    for (int i = 0; i < 4; i++) begin
      memReady = (i == 3);
      expStall = (i < 3);
      @(negedge clk);
      checks++; if (memIf.mem_req !== 1'b1 || memIf.mem_addr !== 32'h0000_0204) $display("FAIL st_req[%0d]: got req %0b addr %h want 1 00000204", i, memIf.mem_req, memIf.mem_addr); else passes++;
      checks++; if (memIf.mem_we !== 1'b1 || memIf.mem_wdata !== 32'hCAFE_0001) $display("FAIL st_data[%0d]: got we %0b data %h want 1 cafe0001", i, memIf.mem_we, memIf.mem_wdata); else passes++;
      checks++; if (stall !== expStall) $display("FAIL st_stall[%0d]: got %0b want %0b", i, stall, expStall); else passes++;
      checks++; if (bus_err !== 1'b0) $display("FAIL st_buserr[%0d]: got %0b want 0", i, bus_err); else passes++;
      nextCycle();
    end
    idleInputs();
    @(negedge clk);
    checks++; if (stall_cycles !== 32'd3) $display("FAIL st_cnt: got %0d want 3", stall_cycles); else passes++;
    checks++; if (memIf.mem_req !== 1'b0) $display("FAIL st_after_req: got %0b want 0", memIf.mem_req); else passes++;
    nextCycle();
  endtask

  task automatic test_misalign();
    applyReset();
    // Ready asserted with no request must be ignored
    MemRead = 1'b1; RegWrite_in = 1'b1; AluResult = 32'h0000_0102;
    memReady = 1'b1; memRdata = 32'h5A5A_5A5A;
    @(negedge clk);
    checks++; if (memIf.mem_req !== 1'b0) $display("FAIL mis_req: got %0b want 0", memIf.mem_req); else passes++;
    checks++; if (misalign !== 1'b1) $display("FAIL mis_pulse: got %0b want 1", misalign); else passes++;
    checks++; if (RegWrite_out !== 1'b0) $display("FAIL mis_regwrite: got %0b want 0", RegWrite_out); else passes++;
    checks++; if (stall !== 1'b0) $display("FAIL mis_stall: got %0b want 0", stall); else passes++;
    checks++; if (rd_data !== 32'h0000_0000) $display("FAIL mis_rdata: got %h want 00000000", rd_data); else passes++;
    nextCycle();
    idleInputs();
    RegWrite_in = 1'b1;
    @(negedge clk);
    checks++; if (misalign !== 1'b0) $display("FAIL mis_one_cycle: got %0b want 0", misalign); else passes++;
    checks++; if (RegWrite_out !== 1'b1) $display("FAIL mis_regwrite_pass: got %0b want 1", RegWrite_out); else passes++;
    checks++; if (stall_cycles !== 32'd0 || rd_data !== 32'h0000_0000) $display("FAIL mis_after: got cnt %0d rdata %h want 0 00000000", stall_cycles, rd_data); else passes++;
    nextCycle();
  endtask

  task automatic test_timeout();
    applyReset();
    MemRead = 1'b1; RegWrite_in = 1'b1; AluResult = 32'h0000_0040;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b1 || memIf.mem_req !== 1'b1) $display("FAIL to_wait[%0d]: got stall %0b req %0b want 1 1", i, stall, memIf.mem_req); else passes++;
      checks++; if (bus_err !== 1'b0) $display("FAIL to_early_err[%0d]: got %0b want 0", i, bus_err); else passes++;
      nextCycle();
    end
    @(negedge clk);
    checks++; if (bus_err !== 1'b1) $display("FAIL to_buserr: got %0b want 1", bus_err); else passes++;
    checks++; if (stall !== 1'b0 || memIf.mem_req !== 1'b0) $display("FAIL to_err_ctl: got stall %0b req %0b want 0 0", stall, memIf.mem_req); else passes++;
    checks++; if (RegWrite_out !== 1'b0) $display("FAIL to_regwrite: got %0b want 0", RegWrite_out); else passes++;
    nextCycle();
    // Back in IDLE: a fresh zero-wait load completes at once
    AluResult = 32'h0000_0044; memReady = 1'b1; memRdata = 32'h0BAD_F00D;
    @(negedge clk);
    checks++; if (memIf.mem_req !== 1'b1 || stall !== 1'b0 || bus_err !== 1'b0) $display("FAIL to_idle: got req %0b stall %0b err %0b want 1 0 0", memIf.mem_req, stall, bus_err); else passes++;
    nextCycle();
    idleInputs();
    @(negedge clk);
    checks++; if (stall_cycles !== 32'd4) $display("FAIL to_cnt: got %0d want 4", stall_cycles); else passes++;
    checks++; if (stall_cycles2 !== 2'd3) $display("FAIL to_cnt_sat: got %0d want 3", stall_cycles2); else passes++;
    nextCycle();
  endtask

  task automatic test_back_to_back();
    applyReset();
    MemRead = 1'b1; RegWrite_in = 1'b1; AluResult = 32'h0000_0010;
    @(negedge clk);
    checks++; if (stall !== 1'b1 || memIf.mem_req !== 1'b1) $display("FAIL b2b_a_wait: got stall %0b req %0b want 1 1", stall, memIf.mem_req); else passes++;
    nextCycle();
    memReady = 1'b1; memRdata = 32'h1111_1111;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || rd_data !== 32'h1111_1111) $display("FAIL b2b_a_done: got stall %0b rdata %h want 0 11111111", stall, rd_data); else passes++;
    nextCycle();
    AluResult = 32'h0000_0014; memReady = 1'b0; memRdata = 32'h0000_0000;
    @(negedge clk);
    checks++; if (memIf.mem_req !== 1'b1 || memIf.mem_addr !== 32'h0000_0014 || stall !== 1'b1) $display("FAIL b2b_b_req: got req %0b addr %h stall %0b want 1 00000014 1", memIf.mem_req, memIf.mem_addr, stall); else passes++;
    nextCycle();
    memReady = 1'b1; memRdata = 32'h2222_2222;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || rd_data !== 32'h2222_2222) $display("FAIL b2b_b_done: got stall %0b rdata %h want 0 22222222", stall, rd_data); else passes++;
    nextCycle();
    idleInputs();
    @(negedge clk);
    checks++; if (stall_cycles !== 32'd2) $display("FAIL b2b_cnt: got %0d want 2", stall_cycles); else passes++;
    checks++; if (rd_data !== 32'h2222_2222) $display("FAIL b2b_rdata_held: got %h want 22222222", rd_data); else passes++;
    nextCycle();
  endtask

  task automatic test_reset_mid_wait();
    applyReset();
    MemRead = 1'b1; RegWrite_in = 1'b1; AluResult = 32'h0000_0080;
    nextCycle();
    nextCycle();
    // Second wait cycle: reset drops the request immediately
    rst = 1'b1;
    @(negedge clk);
    checks++; if (memIf.mem_req !== 1'b0 || stall !== 1'b0) $display("FAIL rw_abort: got req %0b stall %0b want 0 0", memIf.mem_req, stall); else passes++;
    nextCycle();
    rst = 1'b0;
    idleInputs();
    @(negedge clk);
    checks++; if (memIf.mem_req !== 1'b0 || stall !== 1'b0) $display("FAIL rw_after: got req %0b stall %0b want 0 0", memIf.mem_req, stall); else passes++;
    checks++; if (stall_cycles !== 32'd0) $display("FAIL rw_cnt: got %0d want 0", stall_cycles); else passes++;
    nextCycle();
    // Misalign is only flagged from IDLE
    MemRead = 1'b1; AluResult = 32'h0000_0081;
    @(negedge clk);
    checks++; if (misalign !== 1'b1) $display("FAIL rw_idle: got misalign %0b want 1", misalign); else passes++;
    nextCycle();
    idleInputs();
  endtask

  initial begin
    idleInputs();
    rst = 1'b1;
    test_reset();
    test_zero_wait_load();
    test_store_3wait();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
